// File: rtl/fp_accumulate.sv
// Multi-cycle float32 running-sum accumulator (truncating, flush-to-zero, sticky specials).
// Optional feature: define FP_ACC_COUNT_EN to add the acc_count output.
module fp_accumulate #(
    parameter int GUARD_BITS = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic        clear,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
`ifdef FP_ACC_COUNT_EN
    ,
    output logic [15:0] acc_count
`endif
);

    localparam int         SW     = 24 + GUARD_BITS;
    localparam int         LZW    = $clog2(SW + 1);
    localparam logic [7:0] SW_EXP = 8'(SW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_PACK
    } state_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_KEEP,
        SP_NAN
    } special_t;

    function automatic logic f_unpack_sign(input logic [31:0] f);
        return f[31] & (|f[30:23]);
    endfunction

    function automatic logic [SW-1:0] f_unpack_sig(input logic [31:0] f);
        logic [SW-1:0] s;
        if (f[30:23] == 8'h00)
            s = '0;
        else
            s = {1'b1, f[22:0], {GUARD_BITS{1'b0}}};
        return s;
    endfunction

    function automatic logic [LZW-1:0] f_lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i])
                    found = 1'b1;
                else
                    n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    // Truncated result with flush-to-zero underflow and signed-infinity overflow.
    function automatic logic [31:0] f_pack(input logic sign, input logic signed [9:0] exp,
                                           input logic [22:0] frac, input logic zero);
        logic [31:0] w;
        if (zero || (exp <= 10'sd0))
            w = 32'h0000_0000;
        else if (exp >= 10'sd255)
            w = {sign, 8'hFF, 23'h0};
        else
            w = {sign, exp[7:0], frac};
        return w;
    endfunction

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_acc;
`ifdef FP_ACC_COUNT_EN
    logic [15:0] r_count;
`endif

    logic [31:0] r_dataa;
    logic        r_clear;
    special_t    r_special_p0;
    logic        r_sign_a_p0, r_sign_b_p0;
    logic [7:0]  r_exp_a_p0, r_exp_b_p0;
    logic [SW-1:0] r_sig_a_p0, r_sig_b_p0;

    logic        r_sign_l_p1, r_sign_s_p1;
    logic [7:0]  r_exp_l_p1;
    logic [SW-1:0] r_sig_l_p1, r_sig_s_p1;

    logic        r_sign_p2;
    logic [7:0]  r_exp_p2;
    logic [SW:0] r_sum_p2;

    logic        r_sign_p3;
    logic signed [9:0] r_exp_p3;
    logic [22:0] r_frac_p3;
    logic        r_zero_p3;

    logic [31:0]   w_opa;
    special_t      w_special;
    logic          w_a_big;
    logic          w_sign_l, w_sign_s;
    logic [7:0]    w_exp_l, w_exp_s, w_diff;
    logic [SW-1:0] w_sig_l, w_sig_s, w_sig_s_al;
    logic [LZW-1:0] w_lzc;
    logic [31:0]   w_pack;

    assign w_opa = r_clear ? 32'h0000_0000 : r_acc;

    // Sticky accumulator special outranks a special addend.
    always_comb begin
        w_special = SP_NONE;
        if (!r_clear && (r_acc[30:23] == 8'hFF))
            w_special = SP_KEEP;
        else if (r_dataa[30:23] == 8'hFF)
            w_special = SP_NAN;
    end

    always_comb begin
        w_a_big = (r_exp_a_p0 > r_exp_b_p0) ||
                  ((r_exp_a_p0 == r_exp_b_p0) && (r_sig_a_p0 >= r_sig_b_p0));
        w_sign_l = r_sign_b_p0;
        w_sign_s = r_sign_a_p0;
        w_exp_l  = r_exp_b_p0;
        w_exp_s  = r_exp_a_p0;
        w_sig_l  = r_sig_b_p0;
        w_sig_s  = r_sig_a_p0;
        if (w_a_big) begin
            w_sign_l = r_sign_a_p0;
            w_sign_s = r_sign_b_p0;
            w_exp_l  = r_exp_a_p0;
            w_exp_s  = r_exp_b_p0;
            w_sig_l  = r_sig_a_p0;
            w_sig_s  = r_sig_b_p0;
        end
        w_diff     = w_exp_l - w_exp_s;
        w_sig_s_al = (w_diff >= SW_EXP) ? '0 : (w_sig_s >> w_diff);
    end

    assign w_lzc = f_lzc(r_sum_p2[SW-1:0]);

    always_comb begin
        case (r_special_p0)
            SP_NAN:  w_pack = 32'h7FC0_0000;
            SP_KEEP: w_pack = r_acc;
            default: w_pack = f_pack(r_sign_p3, r_exp_p3, r_frac_p3, r_zero_p3);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= 32'h0000_0000;
`ifdef FP_ACC_COUNT_EN
            r_count <= 16'h0000;
`endif
        end else if (clk_en) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_UNPACK;
                        r_busy  <= 1'b1;
                    end
                end
                S_UNPACK: r_state <= S_ALIGN;
                S_ALIGN:  r_state <= S_ADD;
                S_ADD:    r_state <= S_NORM;
                S_NORM:   r_state <= S_PACK;
                S_PACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_acc   <= w_pack;
`ifdef FP_ACC_COUNT_EN
                    if (r_clear)
                        r_count <= 16'h0001;
                    else if (r_count != 16'hFFFF)
                        r_count <= r_count + 16'h0001;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dataa <= dataa;
                        r_clear <= clear;
                    end
                end
                // p0: unpack, flushing exp=0 operands to zero
                S_UNPACK: begin
                    r_special_p0 <= w_special;
                    r_sign_a_p0  <= f_unpack_sign(w_opa);
                    r_exp_a_p0   <= w_opa[30:23];
                    r_sig_a_p0   <= f_unpack_sig(w_opa);
                    r_sign_b_p0  <= f_unpack_sign(r_dataa);
                    r_exp_b_p0   <= r_dataa[30:23];
                    r_sig_b_p0   <= f_unpack_sig(r_dataa);
                end
                // p1: order by magnitude and align the smaller operand
                S_ALIGN: begin
                    r_sign_l_p1 <= w_sign_l;
                    r_sign_s_p1 <= w_sign_s;
                    r_exp_l_p1  <= w_exp_l;
                    r_sig_l_p1  <= w_sig_l;
                    r_sig_s_p1  <= w_sig_s_al;
                end
                // p2: magnitude add or subtract; larger operand sets the sign
                S_ADD: begin
                    r_sign_p2 <= r_sign_l_p1;
                    r_exp_p2  <= r_exp_l_p1;
                    if (r_sign_l_p1 == r_sign_s_p1)
                        r_sum_p2 <= {1'b0, r_sig_l_p1} + {1'b0, r_sig_s_p1};
                    else
                        r_sum_p2 <= {1'b0, r_sig_l_p1} - {1'b0, r_sig_s_p1};
                end
                // p3: normalise, keeping only the fraction bits that survive truncation
                S_NORM: begin
                    r_sign_p3 <= r_sign_p2;
                    r_zero_p3 <= (r_sum_p2 == '0);
                    if (r_sum_p2[SW]) begin
                        r_exp_p3  <= $signed({2'b00, r_exp_p2}) + 10'sd1;
                        r_frac_p3 <= r_sum_p2[SW-1:GUARD_BITS+1];
                    end else begin
                        r_exp_p3  <= $signed({2'b00, r_exp_p2}) -
                                     $signed({{(10-LZW){1'b0}}, w_lzc});
                        r_frac_p3 <= 23'((r_sum_p2[SW-1:0] << w_lzc) >> GUARD_BITS);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_acc;
    assign done   = r_done;
    assign busy   = r_busy;
`ifdef FP_ACC_COUNT_EN
    assign acc_count = r_count;
`endif

endmodule

// File: tb/tb_fp_accumulate.sv
// Scoreboard bench for fp_accumulate: hand-derived float32 sums, latency, clk_en, reset.
module tb_fp_accumulate;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] dataa = 32'h0;
    logic [31:0] result;
    logic        done;
    logic        busy;
`ifdef FP_ACC_COUNT_EN
    logic [15:0] acc_count;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'h0;
    logic        prev_done = 1'b0;

    fp_accumulate #(.GUARD_BITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .clear   (clear),
        .dataa   (dataa),
        .result  (result),
        .done    (done),
        .busy    (busy)
`ifdef FP_ACC_COUNT_EN
        ,
        .acc_count (acc_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Scoreboard: every rising done retires one queued expectation.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (exp_q.size() == 0)
                check("sb_extra_done", {31'b0, done}, 32'd0);
            else
                check("sb_result", result, exp_q.pop_front());
        end
        prev_done = done;
    end

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic run_add(input logic cl, input logic [31:0] a, input logic [31:0] want);
        int cyc;
        start = 1'b1;
        clear = cl;
        dataa = a;
        exp_q.push_back(want);
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
        cyc = 0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        while (!done && cyc < 20) begin
            if (cyc == 2)
                check("result_hold", result, last_res);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'd5);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        last_res = want;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_done;
        logic pd;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_add(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        run_add(1'b0, 32'h4000_0000, 32'h4040_0000);
        run_add(1'b0, 32'hC040_0000, 32'h0000_0000);
        run_add(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        run_add(1'b0, 32'h3380_0000, 32'h3F80_0000);
        run_add(1'b0, 32'h3F00_0000, 32'h3FC0_0000);
        run_add(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        run_add(1'b0, 32'hBF40_0000, 32'h3E80_0000);
        run_add(1'b1, 32'hC000_0000, 32'hC000_0000);
        run_add(1'b0, 32'h3F00_0000, 32'hBFC0_0000);
        run_add(1'b1, 32'h0040_0000, 32'h0000_0000);
        run_add(1'b1, 32'h0080_0000, 32'h0080_0000);
        run_add(1'b0, 32'h80C0_0000, 32'h0000_0000);
        run_add(1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        run_add(1'b0, 32'h7F7F_FFFF, 32'h7F80_0000);
        run_add(1'b0, 32'h3F80_0000, 32'h7F80_0000);
        run_add(1'b1, 32'h7FC0_0001, 32'h7FC0_0000);
        run_add(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        run_add(1'b0, 32'h7F80_0000, 32'h7FC0_0000);
        run_add(1'b0, 32'h3F80_0000, 32'h7FC0_0000);
        check("done_before_b2b", {31'b0, done}, 32'd1);
        run_add(1'b1, 32'h4040_0000, 32'h4040_0000);

        // Freeze three cycles while the FSM sits in ALIGN.
        start = 1'b1; clear = 1'b1; dataa = 32'h4000_0000;
        exp_q.push_back(32'h4000_0000);
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        cyc = 0;
        @(posedge clk); #1;
        cyc++;
        clk_en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("frozen_busy", {31'b0, busy}, 32'd1);
        check("frozen_done", {31'b0, done}, 32'd0);
        clk_en = 1'b1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency_clk_en", 32'(cyc), 32'd8);
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_stretch", {31'b0, done}, 32'd1);
        check("result_stretch", result, 32'h4000_0000);
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("done_drop", {31'b0, done}, 32'd0);
        last_res = 32'h4000_0000;

        // A second start while busy must not be queued.
        start = 1'b1; clear = 1'b1; dataa = 32'h40A0_0000;
        exp_q.push_back(32'h40A0_0000);
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        n_done = 0;
        pd = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 2) begin
                start = 1'b1; clear = 1'b1; dataa = 32'h7FC0_0001;
            end else begin
                start = 1'b0; clear = 1'b0;
            end
            @(posedge clk); #1;
            if (done && !pd)
                n_done++;
            pd = done;
        end
        check("single_done", 32'(n_done), 32'd1);
        check("ignored_start_result", result, 32'h40A0_0000);
        last_res = 32'h40A0_0000;

        // Reset while the add is in the ADD state.
        start = 1'b1; clear = 1'b0; dataa = 32'h3F80_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_result", result, 32'h0);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_quiet", {31'b0, done}, 32'd0);
        last_res = 32'h0;

`ifdef FP_ACC_COUNT_EN
        run_add(1'b1, 32'h3F80_0000, 32'h3F80_0000);
        check("count_1", {16'h0, acc_count}, 32'd1);
        run_add(1'b0, 32'h3F80_0000, 32'h4000_0000);
        check("count_2", {16'h0, acc_count}, 32'd2);
        run_add(1'b0, 32'h3F80_0000, 32'h4040_0000);
        check("count_3", {16'h0, acc_count}, 32'd3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("count_rst", {16'h0, acc_count}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
